seg7_scan_decoder: RTL and testbench
====================================

Name: seg7_scan_decoder

Overview:
Monitors a multiplexed 7-segment display bus (segment lines plus one-hot digit strobes) and reconstructs the displayed multi-digit BCD value. Serves as the receive-side counterpart of the BCD-to-7-segment encoding path. Used for display loop-back self-test and for capturing external panel readouts. Delivers a complete, double-buffered frame with per-digit error flags.

Parameters:
NDIG, 4, number of multiplexed digits (1..8)
STABLE_CYC, 4, consecutive stable clk cycles required before a digit is captured (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
seg_in  input  7  segment lines {a,b,c,d,e,f,g}, bit6=a, 1=lit; asynchronous to clk
dig_in  input  NDIG  digit strobes, active-high, one-hot; bit0 = least significant digit; asynchronous to clk
bcd_out  output  4*NDIG  last complete frame; digit k in bits [4k+3:4k]
digit_err  output  NDIG  per-digit invalid-pattern flags for last frame
frame_err  output  1  OR of digit_err for last frame
frame_valid  output  1  one-cycle pulse when bcd_out/digit_err/frame_err update

Behaviour:
- Reset: bcd_out=0, digit_err=0, frame_err=0, frame_valid=0; synchronizers, stability counter, captured flag, shadow registers and seen mask cleared. Asserting reset mid-frame discards the partial frame.
- Input path: 2-flop synchronizer on {dig_in, seg_in}; all later logic uses the synchronized word W.
- Stability: counter cnt, width $clog2(STABLE_CYC+1). If W differs from the previous W, cnt is set to 1 and captured is cleared; otherwise cnt increments, saturating at STABLE_CYC.
- Capture: when cnt reaches STABLE_CYC, captured=0, and the dig field of W is exactly one-hot, the digit index k is decoded. Shadow slot k is written and seen[k] is set on that edge, and captured is set. This gives one capture per stable window.
- Capture latency: 2 sync cycles plus STABLE_CYC cycles after the input settles.
- dig field zero or multi-hot: treated as a blanking interval. No capture occurs and the counter still runs, with no side effects.
- Pattern decode, inverse of the encode table:
  - 1111110→0
  - 0110000→1
  - 1101101→2
  - 1111001→3
  - 0110011→4
  - 1011011→5
  - 1011111→6
  - 1110000→7
  - 1111111→8
  - 1111011→9
  - Any other pattern, including blank 0000000: slot = 4'hF, shadow error bit k = 1.
  - Valid pattern: shadow error bit k = 0.
- Recapture of a digit already in seen before the frame completes: overwrites slot k (latest wins).
- Frame completion: in the cycle after seen becomes all-ones:
  - frame_valid=1 for exactly one cycle.
  - bcd_out, digit_err and frame_err load from the shadow registers on that same edge.
  - seen clears on that same edge.
- A capture on the completion edge counts toward the next frame: seen is set to only that bit.
- Between frames, outputs hold their last values. Shadow updates are never visible until frame completion.
- NDIG=1: every capture completes a frame.

Decomposition:
- Shared package/include seg7_pkg:
  - Segment pattern constants SEG_0..SEG_9 and SEG_BLANK, with bit order {a..g}, active-high.
  - BCD_ERR = 4'hF.
  - The encoder path uses the same constants.
- Sub-module seg7_to_bcd: combinational, seg[6:0] → {valid, bcd[3:0]}, implementing the inverse table. This is the natural unit-test target.
- Top holds the synchronizer, stability counter, one-hot check, shadow/seen registers and frame output stage.

Test Plan:
- Drive digits 0..3 with patterns for 1,2,3,4, each held 10 cycles, with 2 blank cycles (dig=0) between → one frame_valid pulse; bcd_out=16'h4321, digit_err=4'b0000, frame_err=0.
- Digit 2 driven with 1010101, others valid 7,0,9 → bcd_out=16'h9F07 (digit3=9), digit_err=4'b0100, frame_err=1.
- Digit 1 held for only 3 synced cycles (STABLE_CYC=4) with pattern 8, then dig=0 → no capture; seen[1] stays 0; frame_valid does not pulse.
- dig_in=4'b0011 held 20 cycles → no capture and no state change. Then dig_in=4'b0001 with pattern 5 held → slot0=5 after 2+4 cycles.
- Digit 0 captured as 3, then 6 before the frame completes; remaining digits valid → bcd_out[3:0]=6.
- rst_n pulsed low after 2 of 4 digits are captured → outputs 0 immediately. The next full 4-digit scan produces exactly one frame_valid, with no stale digits.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions used by both the encode and the decode paths.
// Segment bit order is {a,b,c,d,e,f,g}, active-high.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [3:0] BCD_ERR   = 4'hF;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational inverse of the BCD-to-7-segment table; any pattern outside
// the table (including blank) reports invalid with BCD_ERR.
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic       valid,
    output logic [3:0] bcd
);

    // Pattern lookup
    always_comb begin
        valid = 1'b1;
        bcd   = BCD_ERR;
        case (seg)
            SEG_0:     bcd = 4'd0;
            SEG_1:     bcd = 4'd1;
            SEG_2:     bcd = 4'd2;
            SEG_3:     bcd = 4'd3;
            SEG_4:     bcd = 4'd4;
            SEG_5:     bcd = 4'd5;
            SEG_6:     bcd = 4'd6;
            SEG_7:     bcd = 4'd7;
            SEG_8:     bcd = 4'd8;
            SEG_9:     bcd = 4'd9;
            SEG_BLANK: begin
                valid = 1'b0;
                bcd   = BCD_ERR;
            end
            default: begin
                valid = 1'b0;
                bcd   = BCD_ERR;
            end
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Reconstructs a multi-digit BCD value from a multiplexed 7-segment bus and
// publishes it as a double-buffered frame with per-digit error flags.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          seg_in,
    input  logic [NDIG-1:0]     dig_in,
    output logic [4*NDIG-1:0]   bcd_out,
    output logic [NDIG-1:0]     digit_err,
    output logic                frame_err,
    output logic                frame_valid
);

    localparam int              CW       = $clog2(STABLE_CYC + 1);
    localparam int              WW       = NDIG + 7;
    localparam logic [CW-1:0]   CNT_MAX  = CW'(STABLE_CYC);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [NDIG-1:0] DIG_ONE  = NDIG'(1);
    localparam logic [NDIG-1:0] DIG_ZERO = NDIG'(0);
    localparam logic [NDIG-1:0] SEEN_ALL = {NDIG{1'b1}};

    logic [WW-1:0]     sync1_r;
    logic [WW-1:0]     sync2_r;
    logic [WW-1:0]     wprev_r;
    logic [CW-1:0]     cnt_r;
    logic [CW-1:0]     cnt_s;
    logic              captured_r;
    logic              captured_s;
    logic              changed_s;
    logic              onehot_s;
    logic              capture_s;
    logic [NDIG-1:0]   dig_s;
    logic [6:0]        seg_s;
    logic              dec_valid_s;
    logic [3:0]        dec_bcd_s;
    logic [NDIG-1:0]   cap_mask_s;
    logic [NDIG-1:0]   seen_r;
    logic [NDIG-1:0]   seen_s;
    logic              complete_s;
    logic [4*NDIG-1:0] shadow_bcd_r;
    logic [NDIG-1:0]   shadow_err_r;
    logic [4*NDIG-1:0] bcd_r;
    logic [NDIG-1:0]   err_r;
    logic              ferr_r;
    logic              fv_r;

    assign dig_s = sync2_r[WW-1:7];
    assign seg_s = sync2_r[6:0];

    seg7_to_bcd u_dec (
        .seg   (seg_s),
        .valid (dec_valid_s),
        .bcd   (dec_bcd_s)
    );

    // Stability window and one-capture-per-window qualification
    always_comb begin
        changed_s = (sync2_r != wprev_r);
        if (changed_s) begin
            cnt_s = CNT_ONE;
        end else if (cnt_r == CNT_MAX) begin
            cnt_s = cnt_r;
        end else begin
            cnt_s = cnt_r + CNT_ONE;
        end
        onehot_s  = (dig_s != DIG_ZERO) && ((dig_s & (dig_s - DIG_ONE)) == DIG_ZERO);
        // A changed word starts a fresh window, so the old captured flag no longer blocks
        capture_s = (cnt_s == CNT_MAX) && (changed_s || !captured_r) && onehot_s;
        if (capture_s) begin
            captured_s = 1'b1;
        end else if (changed_s) begin
            captured_s = 1'b0;
        end else begin
            captured_s = captured_r;
        end
        cap_mask_s = capture_s ? dig_s : DIG_ZERO;
        complete_s = (seen_r == SEEN_ALL);
        seen_s     = complete_s ? cap_mask_s : (seen_r | cap_mask_s);
    end

    // Input synchronizer and stability counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r    <= '0;
            sync2_r    <= '0;
            wprev_r    <= '0;
            cnt_r      <= '0;
            captured_r <= 1'b0;
        end else begin
            sync1_r    <= {dig_in, seg_in};
            sync2_r    <= sync1_r;
            wprev_r    <= sync2_r;
            cnt_r      <= cnt_s;
            captured_r <= captured_s;
        end
    end

    // Shadow slots and seen mask for the frame being assembled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_bcd_r <= '0;
            shadow_err_r <= '0;
            seen_r       <= '0;
        end else begin
            for (int k = 0; k < NDIG; k++) begin
                if (cap_mask_s[k]) begin
                    shadow_bcd_r[4*k +: 4] <= dec_bcd_s;
                    shadow_err_r[k]        <= ~dec_valid_s;
                end
            end
            seen_r <= seen_s;
        end
    end

    // Frame output stage; loads the old shadow even if a new capture lands on this edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_r  <= '0;
            err_r  <= '0;
            ferr_r <= 1'b0;
            fv_r   <= 1'b0;
        end else begin
            fv_r <= complete_s;
            if (complete_s) begin
                bcd_r  <= shadow_bcd_r;
                err_r  <= shadow_err_r;
                ferr_r <= |shadow_err_r;
            end else begin
                bcd_r  <= bcd_r;
                err_r  <= err_r;
                ferr_r <= ferr_r;
            end
        end
    end

    assign bcd_out     = bcd_r;
    assign digit_err   = err_r;
    assign frame_err   = ferr_r;
    assign frame_valid = fv_r;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench: stimulus pushes expected frames from a table-lookup model,
// a negedge monitor pops and compares on every frame_valid and checks holding.
module tb_seg7_scan_decoder;

    localparam int NDIG       = 4;
    localparam int STABLE_CYC = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [6:0]          seg_in;
    logic [NDIG-1:0]     dig_in;
    logic [4*NDIG-1:0]   bcd_out;
    logic [NDIG-1:0]     digit_err;
    logic                frame_err;
    logic                frame_valid;

    always #5 clk = ~clk;

    seg7_scan_decoder #(.NDIG(NDIG), .STABLE_CYC(STABLE_CYC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .dig_in      (dig_in),
        .bcd_out     (bcd_out),
        .digit_err   (digit_err),
        .frame_err   (frame_err),
        .frame_valid (frame_valid)
    );

    typedef struct {
        logic [4*NDIG-1:0] bcd;
        logic [NDIG-1:0]   err;
    } frame_t;

    int          checks   = 0;
    int          failures = 0;
    frame_t      exp_q[$];
    frame_t      hold_f;
    frame_t      got_f;
    logic [6:0]  seg_tab [10];
    logic [3:0]  m_slot  [NDIG];
    bit          m_seen  [NDIG];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [3:0] ref_decode(logic [6:0] p);
        for (int i = 0; i < 10; i++) begin
            if (seg_tab[i] == p) return 4'(i);
        end
        return 4'hF;
    endfunction

    // Model: a qualifying hold records the digit; a full set of digits becomes a frame
    function automatic void model_capture(int k, logic [6:0] p);
        frame_t fr;
        bit     all;
        m_slot[k] = ref_decode(p);
        m_seen[k] = 1'b1;
        all = 1'b1;
        for (int i = 0; i < NDIG; i++) all &= m_seen[i];
        if (all) begin
            for (int i = 0; i < NDIG; i++) begin
                fr.bcd[4*i +: 4] = m_slot[i];
                fr.err[i]        = (m_slot[i] == 4'hF);
                m_seen[i]        = 1'b0;
            end
            exp_q.push_back(fr);
        end
    endfunction

    task automatic show(logic [NDIG-1:0] d, logic [6:0] s, int n);
        dig_in = d;
        seg_in = s;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic blank(int n);
        show('0, 7'($urandom_range(0, 127)), n);
    endtask

    task automatic scan_digit(int k, logic [6:0] p, int n);
        model_capture(k, p);
        show(NDIG'(1) << k, p, n);
        blank(2);
    endtask

    task automatic glitch(int k, logic [6:0] p, int n);
        show(NDIG'(1) << k, p, n);
        blank(2);
    endtask

    // Monitor: reset zeros, frame pops, and output holding between frames
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_bcd", 32'(bcd_out), 32'h0);
            check("rst_err", 32'(digit_err), 32'h0);
            check("rst_ferr", 32'(frame_err), 32'h0);
            check("rst_fv", 32'(frame_valid), 32'h0);
            hold_f.bcd = '0;
            hold_f.err = '0;
        end else if (frame_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_frame: got frame_valid=1 bcd=%h expected no frame", bcd_out);
            end else begin
                got_f = exp_q.pop_front();
                check("frame_bcd", 32'(bcd_out), 32'(got_f.bcd));
                check("frame_err_bits", 32'(digit_err), 32'(got_f.err));
                check("frame_err_or", 32'(frame_err), 32'(|got_f.err));
                hold_f = got_f;
            end
        end else begin
            check("hold_bcd", 32'(bcd_out), 32'(hold_f.bcd));
            check("hold_err", 32'(digit_err), 32'(hold_f.err));
            check("hold_ferr", 32'(frame_err), 32'(|hold_f.err));
        end
    end

    initial begin
        int order [NDIG];
        int tmp;
        int j;
        logic [6:0] p;

        seg_tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
        for (int i = 0; i < NDIG; i++) begin
            m_slot[i] = 4'h0;
            m_seen[i] = 1'b0;
        end
        hold_f.bcd = '0;
        hold_f.err = '0;
        dig_in = '0;
        seg_in = '0;
        rst_n  = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        blank(3);

        // Clean frame 4321
        scan_digit(0, seg_tab[1], 10);
        scan_digit(1, seg_tab[2], 10);
        scan_digit(2, seg_tab[3], 10);
        scan_digit(3, seg_tab[4], 10);

        // Invalid pattern on digit 2 -> 9F07
        scan_digit(0, seg_tab[7], 10);
        scan_digit(1, seg_tab[0], 10);
        scan_digit(2, 7'b1010101, 10);
        scan_digit(3, seg_tab[9], 10);

        // Too-short hold is ignored; exactly STABLE_CYC cycles captures
        glitch(1, seg_tab[8], STABLE_CYC - 1);
        scan_digit(0, seg_tab[2], 10);
        scan_digit(2, seg_tab[5], 10);
        scan_digit(3, seg_tab[6], 10);
        scan_digit(1, seg_tab[3], STABLE_CYC);

        // Multi-hot strobe is a blanking interval
        show(4'b0011, seg_tab[8], 20);
        blank(2);
        scan_digit(0, seg_tab[5], 2 + STABLE_CYC);
        scan_digit(1, seg_tab[1], 10);
        scan_digit(2, seg_tab[1], 10);
        scan_digit(3, 7'b0000000, 10);

        // Recapture before completion: latest wins
        scan_digit(0, seg_tab[3], 10);
        scan_digit(0, seg_tab[6], 10);
        scan_digit(1, seg_tab[8], 10);
        scan_digit(2, seg_tab[0], 10);
        scan_digit(3, seg_tab[2], 10);

        // Reset mid-frame discards the partial frame
        scan_digit(0, seg_tab[9], 10);
        scan_digit(1, seg_tab[9], 10);
        rst_n = 1'b0;
        for (int i = 0; i < NDIG; i++) m_seen[i] = 1'b0;
        blank(2);
        rst_n = 1'b1;
        blank(2);
        scan_digit(0, seg_tab[4], 10);
        scan_digit(1, seg_tab[7], 10);
        scan_digit(2, seg_tab[8], 10);
        scan_digit(3, seg_tab[5], 10);

        // Randomized scans with glitches, multi-hot gaps and recaptures
        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < NDIG; i++) order[i] = i;
            for (int i = NDIG - 1; i > 0; i--) begin
                j = $urandom_range(0, i);
                tmp = order[i];
                order[i] = order[j];
                order[j] = tmp;
            end
            for (int i = 0; i < NDIG; i++) begin
                if ($urandom_range(0, 4) == 0) begin
                    glitch($urandom_range(0, NDIG - 1), 7'($urandom_range(0, 127)),
                           $urandom_range(1, STABLE_CYC - 1));
                end
                if ($urandom_range(0, 6) == 0) begin
                    show(4'b0110 | 4'($urandom_range(0, 15)), 7'($urandom_range(0, 127)),
                         $urandom_range(2, 12));
                    blank($urandom_range(2, 4));
                end
                if ($urandom_range(0, 4) == 0)
                    p = 7'($urandom_range(0, 127));
                else
                    p = seg_tab[$urandom_range(0, 9)];
                if (i < NDIG - 1 && $urandom_range(0, 5) == 0)
                    scan_digit(order[i], seg_tab[$urandom_range(0, 9)], $urandom_range(STABLE_CYC, 12));
                scan_digit(order[i], p, $urandom_range(STABLE_CYC, 12));
            end
        end

        blank(10);
        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
